// File: rtl/dft_frame_ctrl_pkg.sv
// Shared types and packing helpers for the 16-point DFT frame sequencer.
package dft_ctrl_pkg;

  localparam int N  = 16;  // samples / bins per frame
  localparam int SW = 6;   // sample width
  localparam int BW = 16;  // bin component width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CALC  = 2'd2,
    ST_DRAIN = 2'd3
  } dft_ctrl_state_t;

  // Return a copy of the parallel sample bus with slot k replaced by val.
  function automatic logic [N*SW-1:0] put_sample(input logic [N*SW-1:0] bus,
                                                 input logic [3:0]      k,
                                                 input logic [SW-1:0]   val);
    logic [N*SW-1:0] res;
    res = bus;
    res[int'(k)*SW +: SW] = val;
    return res;
  endfunction

  // Extract bin k from a packed 16-bin bus.
  function automatic logic [BW-1:0] get_bin(input logic [N*BW-1:0] bus,
                                            input logic [3:0]      k);
    return bus[int'(k)*BW +: BW];
  endfunction

endpackage

// File: rtl/dft_frame_ctrl_if.sv
// Sample-in and bin-out stream handshakes of the DFT frame sequencer.
interface dft_frame_ctrl_if;
  import dft_ctrl_pkg::*;

  logic          s_valid;
  logic          s_ready;
  logic [SW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [BW-1:0] m_re;
  logic [BW-1:0] m_im;
  logic [3:0]    m_bin;
  logic          m_last;

  // Environment side: sample source and bin consumer.
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_re, m_im, m_bin, m_last
  );

  // Sequencer side.
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_re, m_im, m_bin, m_last
  );

endinterface

// File: rtl/dft_frame_ctrl_bin_buf.sv
// Capture register for the 16 complex DFT bins, read one bin at a time.
module dft_bin_buf
  import dft_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cap_en_i,
  input  logic [N*BW-1:0] re_i,
  input  logic [N*BW-1:0] im_i,
  input  logic [3:0]      rd_idx_i,
  output logic [BW-1:0]   re_o,
  output logic [BW-1:0]   im_o
);

  logic [N*BW-1:0] re_q;
  logic [N*BW-1:0] im_q;

  // Snapshot all bins when enabled; otherwise hold so downstream sees a stable frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_q <= '0;
      im_q <= '0;
    end else if (cap_en_i) begin
      re_q <= re_i;
      im_q <= im_i;
    end else begin
      re_q <= re_q;
      im_q <= im_q;
    end
  end

  assign re_o = get_bin(re_q, rd_idx_i);
  assign im_o = get_bin(im_q, rd_idx_i);

endmodule

// File: rtl/dft_frame_ctrl.sv
// Frame sequencer: fills the DFT input bus, waits for settling, drains bins.
module dft_frame_ctrl
  import dft_ctrl_pkg::*;
#(
  parameter int CALC_CYCLES = 2560,
  parameter int CNT_W       = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  dft_frame_ctrl_if.slave bus,
  output logic [N*SW-1:0] dft_x_o,
  output logic            dft_start_o,
  input  logic [N*BW-1:0] dft_re_i,
  input  logic [N*BW-1:0] dft_im_i,
  output logic            busy_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CALC_CYCLES - 1);

  dft_ctrl_state_t state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [3:0]      bin_q, bin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N*SW-1:0] x_q, x_d;
  logic            start_q, start_d;
  logic            cap_s;
  logic            s_acc_s;
  logic            m_acc_s;

  assign s_acc_s = bus.s_valid & (state_q == ST_FILL);
  assign m_acc_s = bus.m_ready & (state_q == ST_DRAIN);

  // Next-state logic; flush overrides every handshake outside IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    start_d = 1'b0;
    cap_s   = 1'b0;
    if (flush_i && (state_q != ST_IDLE)) begin
      state_d = ST_FILL;
      idx_d   = 4'd0;
      bin_d   = 4'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FILL;
        end
        ST_FILL: begin
          if (s_acc_s) begin
            x_d = put_sample(x_q, idx_q, bus.s_data);
            if (idx_q == 4'd15) begin
              idx_d   = 4'd0;
              cnt_d   = '0;
              start_d = 1'b1;
              state_d = ST_CALC;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end else begin
            idx_d = idx_q;
          end
        end
        ST_CALC: begin
          if (cnt_q == CNT_LAST) begin
            cap_s   = 1'b1;
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (m_acc_s) begin
            if (bin_q == 4'd15) begin
              bin_d   = 4'd0;
              state_d = ST_FILL;
            end else begin
              bin_d = bin_q + 4'd1;
            end
          end else begin
            bin_d = bin_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control and sample-bus state; reset wipes any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      bin_q   <= 4'd0;
      cnt_q   <= '0;
      x_q     <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      start_q <= start_d;
    end
  end

  dft_bin_buf u_bin_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap_en_i (cap_s),
    .re_i     (dft_re_i),
    .im_i     (dft_im_i),
    .rd_idx_i (bin_q),
    .re_o     (bus.m_re),
    .im_o     (bus.m_im)
  );

  assign bus.s_ready = (state_q == ST_FILL);
  assign bus.m_valid = (state_q == ST_DRAIN);
  assign bus.m_bin   = bin_q;
  assign bus.m_last  = (state_q == ST_DRAIN) && (bin_q == 4'd15);
  assign busy_o      = (state_q == ST_CALC) || (state_q == ST_DRAIN);
  assign dft_x_o     = x_q;
  assign dft_start_o = start_q;

endmodule
